// File: rtl/filter_pkg.sv
// Shared types and default widths for the filter output capture block.
package filter_pkg;

  // Frame capture state machine states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 33;
  localparam int OUT_W_DEF  = 16;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with extra pointer bit for full/empty.
// A write into a full FIFO succeeds only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_rd, do_wr;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level   = wptr - rptr;
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  // Head is gated so an empty FIFO shows zero rather than stale storage
  assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

  // Pointer update; flush empties the FIFO and overrides both ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/filter_out_capture.sv
// Captures one frame of filter output: round/shift/saturate each sample,
// register it, then push it into a FWFT FIFO for a downstream reader.
module filter_out_capture
  import filter_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int SHIFT     = 15,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 129
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     valid_in,
  input  logic                     clr,
  input  logic                     rd_ready,
  output logic [OUT_W-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     frame_done
);
  localparam int SUM_W = DATA_W + 1;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1) << (SHIFT - 1);
  localparam logic signed [SUM_W-1:0] QMAX = SUM_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] QMIN = -QMAX - SUM_W'(1);

  state_t                   state;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     accept, pop;
  logic signed [SUM_W-1:0]  sum, shifted;
  logic [OUT_W-1:0]         q;
  logic                     s1_vld;
  logic [OUT_W-1:0]         s1_data;
  logic                     full, empty;

  // Samples arriving in DONE, or alongside clr, are discarded
  assign accept  = valid_in && (state != DONE) && !clr;
  assign pop     = rd_valid && rd_ready;
  assign cnt_nxt = cnt + 1'b1;

  // Round half up, arithmetic shift, then clamp to the output range
  always_comb begin
    sum     = $signed({data_in[DATA_W-1], data_in}) + HALF;
    shifted = sum >>> SHIFT;
    if (shifted > QMAX)      q = QMAX[OUT_W-1:0];
    else if (shifted < QMIN) q = QMIN[OUT_W-1:0];
    else                     q = shifted[OUT_W-1:0];
  end

  // Frame FSM and accepted-sample counter; frame_done is registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else if (clr) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else if (accept) begin
      cnt <= cnt_nxt;
      if (cnt_nxt == CNT_W'(FRAME_LEN)) begin
        state      <= DONE;
        frame_done <= 1'b1;
      end else begin
        state <= CAPTURE;
      end
    end
  end

  // Stage 1: hold the quantized sample for one cycle before the FIFO write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) s1_data <= q;
    end
  end

  // Sticky drop flag: a stage-2 write found the FIFO full with no pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          overflow <= 1'b0;
    else if (clr)                        overflow <= 1'b0;
    else if (s1_vld && full && !pop)     overflow <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (clr),
    .wr_en   (s1_vld),
    .wr_data (s1_data),
    .rd_en   (rd_ready),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign rd_valid = !empty;

endmodule

// File: tb/tb_filter_out_capture.sv
// Scoreboard bench: stimulus pushes expected quantized words, a negedge
// monitor pops and compares on every handshake the DUT will complete.
module tb_filter_out_capture;
  localparam int DATA_W = 33;
  localparam int OUT_W  = 16;
  localparam int DEPTH  = 16;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              valid_in = 1'b0;
  logic              clr = 1'b0;
  logic              rd_ready = 1'b0;
  logic [OUT_W-1:0]  rd_data;
  logic              rd_valid;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              frame_done;

  int total = 0;
  int bad   = 0;
  logic [OUT_W-1:0] sb[$];

  filter_out_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .clr        (clr),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .level      (level),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: a handshake visible at negedge completes on the next posedge
  always @(negedge clk) begin
    if (rst_n && !clr && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop got=%0h exp=none", rd_data);
      end else begin
        chk("pop_data", 32'(rd_data), 32'(sb.pop_front()));
      end
    end
  end

  function automatic logic [DATA_W-1:0] scaled(input int k);
    return DATA_W'(k) << 15;
  endfunction

  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic c);
    valid_in = v;
    data_in  = d;
    rd_ready = r;
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic r, input logic [OUT_W-1:0] exp);
    sb.push_back(exp);
    step(1'b1, d, r, 1'b0);
  endtask

  task automatic drain(input int n, input string name);
    repeat (n) step(1'b0, '0, 1'b1, 1'b0);
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Quantization vectors, including both saturation limits
    send(33'd32768, 1'b1, 16'd1);
    send(33'd16384, 1'b1, 16'd1);
    send(33'd16383, 1'b1, 16'd0);
    send(33'h1_FFFF_BFFF, 1'b1, 16'hFFFF);
    send(33'h0_FFFF_FFFF, 1'b1, 16'h7FFF);
    send(33'h1_0000_0000, 1'b1, 16'h8000);
    drain(4, "quant_drain");
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr_frame_done", 32'(frame_done), 32'd0);

    // Full frame with continuous reader
    for (int i = 0; i < 129; i++) begin
      send(scaled(i), 1'b1, OUT_W'(i));
      if (i == 127) chk("frame_done_early", 32'(frame_done), 32'd0);
    end
    chk("frame_done_set", 32'(frame_done), 32'd1);
    step(1'b1, scaled(99), 1'b1, 1'b0);
    drain(4, "frame_drain");
    chk("frame_level", 32'(level), 32'd0);
    chk("frame_done_hold", 32'(frame_done), 32'd1);

    // clr in DONE then three samples
    step(1'b0, '0, 1'b0, 1'b1);
    send(scaled(7), 1'b0, 16'd7);
    send(scaled(8), 1'b0, 16'd8);
    send(scaled(9), 1'b0, 16'd9);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("clr3_level", 32'(level), 32'd3);
    chk("clr3_frame_done", 32'(frame_done), 32'd0);
    chk("clr3_overflow", 32'(overflow), 32'd0);
    drain(5, "clr3_drain");

    // Overflow: 20 samples into a stalled FIFO
    step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      if (k < 16) sb.push_back(OUT_W'(k + 200));
      step(1'b1, scaled(k + 200), 1'b0, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    drain(20, "ovf_drain");
    chk("ovf_sticky", 32'(overflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous write and pop
    for (int k = 0; k < 16; k++) send(scaled(k + 300), 1'b0, OUT_W'(k + 300));
    step(1'b0, '0, 1'b0, 1'b0);
    chk("full_level", 32'(level), 32'd16);
    send(scaled(316), 1'b0, 16'd316);
    for (int k = 317; k < 320; k++) begin
      send(scaled(k), 1'b1, OUT_W'(k));
      chk("full_pop_level", 32'(level), 32'd16);
      chk("full_pop_overflow", 32'(overflow), 32'd0);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("full_last_level", 32'(level), 32'd16);
    chk("full_last_overflow", 32'(overflow), 32'd0);
    drain(20, "full_drain");

    // Asynchronous reset mid-frame with five samples queued
    step(1'b0, '0, 1'b0, 1'b1);
    repeat (5) step(1'b1, scaled(55), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("arst_pre_level", 32'(level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    send(scaled(42), 1'b1, 16'd42);
    drain(4, "arst_drain");
    chk("arst_final_level", 32'(level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
